axis_load_router: RTL and testbench



---
 rtl/axis_load_router.sv | 202 ++++++++++++++++++++
 tb/tb_axis_load_router.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_load_router.sv
// axis_load_router: steers one AXI4-Stream packet per command into one of
// NUM_DEST buffer write ports. It checks the packet length against TLAST and
// drains any overlong tail. Framing and destination errors are reported as
// one-cycle pulses that accompany (or precede) the done pulse.
module axis_load_router #(
    parameter int DATA_W   = 32,
    parameter int NUM_DEST = 4,
    parameter int LEN_W    = 16,
    parameter int DEST_W   = $clog2(NUM_DEST)
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [DEST_W-1:0]   cmd_dest,
    input  logic [LEN_W-1:0]    cmd_len,

    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic                s_axis_tlast,

    output logic [NUM_DEST-1:0] wr_en,
    output logic [LEN_W-1:0]    wr_addr,
    output logic [DATA_W-1:0]   wr_data,

    output logic                busy,
    output logic                done,
    output logic                err_early_last,
    output logic                err_missing_last,
    output logic                err_bad_dest
);

    // NUM_DEST widened by one bit so that every cmd_dest encoding compares
    // cleanly, including non-power-of-two destination counts.
    localparam logic [DEST_W:0] NUM_DEST_V = (DEST_W+1)'(NUM_DEST);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;

    // Latched command and beat counter.
    logic [DEST_W-1:0]   dest_q;
    logic [DEST_W-1:0]   dest_nxt;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    len_nxt;
    logic [LEN_W-1:0]    cnt_q;
    logic [LEN_W-1:0]    cnt_nxt;
    logic [LEN_W-1:0]    last_idx;

    // Stage p0 decisions, registered into the p1 output stage.
    logic                beat_p0;
    logic                wr_p0;
    logic [NUM_DEST-1:0] wr_en_p0;
    logic                done_p0;
    logic                early_p0;
    logic                missing_p0;
    logic                bad_p0;

    logic [NUM_DEST-1:0] wr_en_p1;
    logic [LEN_W-1:0]    wr_addr_p1;
    logic [DATA_W-1:0]   wr_data_p1;
    logic                done_p1;
    logic                early_p1;
    logic                missing_p1;
    logic                bad_p1;

    // Handshake readies are decoded from the state register only; cmd_ready is
    // also held low while reset is asserted.
    assign cmd_ready     = (state == S_IDLE) && !rst;
    assign s_axis_tready = (state == S_LOAD) || (state == S_DRAIN);
    assign busy          = (state != S_IDLE);

    assign beat_p0  = s_axis_tvalid && s_axis_tready;
    assign last_idx = len_q - 1'b1;

    // Next-state, command latching and pulse decisions for the current cycle.
    always_comb begin
        state_nxt  = state;
        dest_nxt   = dest_q;
        len_nxt    = len_q;
        cnt_nxt    = cnt_q;
        wr_p0      = 1'b0;
        done_p0    = 1'b0;
        early_p0   = 1'b0;
        missing_p0 = 1'b0;
        bad_p0     = 1'b0;

        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if ({1'b0, cmd_dest} >= NUM_DEST_V) begin
                        bad_p0  = 1'b1;
                        done_p0 = 1'b1;
                    end else if (cmd_len == '0) begin
                        done_p0 = 1'b1;
                    end else begin
                        dest_nxt  = cmd_dest;
                        len_nxt   = cmd_len;
                        cnt_nxt   = '0;
                        state_nxt = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                if (beat_p0) begin
                    wr_p0 = 1'b1;
                    if (s_axis_tlast) begin
                        // cnt never exceeds last_idx, so a mismatch means short.
                        early_p0  = (cnt_q != last_idx);
                        done_p0   = 1'b1;
                        state_nxt = S_DONE;
                    end else if (cnt_q == last_idx) begin
                        missing_p0 = 1'b1;
                        state_nxt  = S_DRAIN;
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end
            end

            S_DRAIN: begin
                if (beat_p0 && s_axis_tlast) begin
                    done_p0   = 1'b1;
                    state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // One-hot write strobe for the latched destination.
    always_comb begin
        wr_en_p0 = '0;
        for (int i = 0; i < NUM_DEST; i++) begin
            wr_en_p0[i] = wr_p0 && (dest_q == DEST_W'(i));
        end
    end

    // State register and latched command; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            dest_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
        end else begin
            state  <= state_nxt;
            dest_q <= dest_nxt;
            len_q  <= len_nxt;
            cnt_q  <= cnt_nxt;
        end
    end

    // ---- stage p0 -> p1: registered write port and status pulses ----
    // Write port and pulses register one cycle behind the accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_p1   <= '0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
            done_p1    <= 1'b0;
            early_p1   <= 1'b0;
            missing_p1 <= 1'b0;
            bad_p1     <= 1'b0;
        end else begin
            wr_en_p1   <= wr_en_p0;
            done_p1    <= done_p0;
            early_p1   <= early_p0;
            missing_p1 <= missing_p0;
            bad_p1     <= bad_p0;
            if (wr_p0) begin
                wr_addr_p1 <= cnt_q;
                wr_data_p1 <= s_axis_tdata;
            end
        end
    end

    assign wr_en            = wr_en_p1;
    assign wr_addr          = wr_addr_p1;
    assign wr_data          = wr_data_p1;
    assign done             = done_p1;
    assign err_early_last   = early_p1;
    assign err_missing_last = missing_p1;
    assign err_bad_dest     = bad_p1;

endmodule

// File: tb/tb_axis_load_router.sv
// Scoreboard bench for axis_load_router: commands push expected writes and
// completions; a monitor pops them whenever the DUT writes or signals done.
module tb_axis_load_router;

    localparam int DATA_W   = 32;
    localparam int NUM_DEST = 3;
    localparam int LEN_W    = 16;
    localparam int DEST_W   = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [DEST_W-1:0]   cmd_dest = '0;
    logic [LEN_W-1:0]    cmd_len = '0;
    logic                s_axis_tvalid = 1'b0;
    logic                s_axis_tready;
    logic [DATA_W-1:0]   s_axis_tdata = '0;
    logic                s_axis_tlast = 1'b0;
    logic [NUM_DEST-1:0] wr_en;
    logic [LEN_W-1:0]    wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                busy;
    logic                done;
    logic                err_early_last;
    logic                err_missing_last;
    logic                err_bad_dest;

    axis_load_router #(
        .DATA_W(DATA_W), .NUM_DEST(NUM_DEST), .LEN_W(LEN_W), .DEST_W(DEST_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dest(cmd_dest), .cmd_len(cmd_len),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done),
        .err_early_last(err_early_last), .err_missing_last(err_missing_last),
        .err_bad_dest(err_bad_dest)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          dest;
        int          addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        bit early;
        bit missing;
        bit bad;
        bit wsame;
    } comp_t;

    wr_t   wq[$];
    comp_t cq[$];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    bit acc_early = 1'b0;
    bit acc_missing = 1'b0;
    bit acc_bad = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop expectations whenever the DUT writes or completes.
    always @(negedge clk) begin
        wr_t   w;
        comp_t c;
        bit    wrote;
        if (mon_en && !rst) begin
            wrote = (wr_en != '0);
            acc_early   = acc_early   | err_early_last;
            acc_missing = acc_missing | err_missing_last;
            acc_bad     = acc_bad     | err_bad_dest;
            if (wrote) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", 64'(wr_en), 64'd0);
                end else begin
                    w = wq.pop_front();
                    chk("wr_en",   64'(wr_en),   64'(1 << w.dest));
                    chk("wr_addr", 64'(wr_addr), 64'(w.addr));
                    chk("wr_data", 64'(wr_data), 64'(w.data));
                end
            end
            if (done) begin
                if (cq.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    c = cq.pop_front();
                    chk("err_early_last",   64'(acc_early),   64'(c.early));
                    chk("err_missing_last", 64'(acc_missing), 64'(c.missing));
                    chk("err_bad_dest",     64'(acc_bad),     64'(c.bad));
                    chk("writes_left_at_done", 64'(wq.size()), 64'd0);
                    chk("last_write_with_done", 64'(wrote), 64'(c.wsame));
                end
                acc_early   = 1'b0;
                acc_missing = 1'b0;
                acc_bad     = 1'b0;
            end
        end
    end

    task automatic issue_cmd(input int dest, input int len);
        int g;
        g = 0;
        cmd_valid = 1'b1;
        cmd_dest  = DEST_W'(dest);
        cmd_len   = LEN_W'(len);
        while (!cmd_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) chk("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_len   = LEN_W'($urandom);
    endtask

    // mode: 0 continuous, 1 alternating bubbles, 2 random bubbles.
    // abort_at > 0: pulse rst after that many beats and abandon the packet.
    task automatic run(input int dest, input int len, input int plen,
                       input int mode, input int abort_at);
        logic [31:0] d[$];
        comp_t c;
        wr_t   w;
        int    n;
        int    g;
        bool_loop: begin end
        for (int i = 0; i < plen; i++) d.push_back($urandom);
        c.early = 0; c.missing = 0; c.bad = 0; c.wsame = 0;
        if (dest >= NUM_DEST) begin
            c.bad = 1;
        end else if (len > 0) begin
            n = (plen < len) ? plen : len;
            for (int i = 0; i < n; i++) begin
                w.dest = dest; w.addr = i; w.data = d[i];
                wq.push_back(w);
            end
            c.early   = (plen < len);
            c.missing = (plen > len);
            c.wsame   = !c.missing;
        end
        if (abort_at == 0) cq.push_back(c);
        issue_cmd(dest, len);

        if (dest < NUM_DEST && len > 0) begin
            for (int i = 0; i < plen; i++) begin
                if (abort_at > 0 && i >= abort_at) break;
                if ((mode == 1 && i > 0) || (mode == 2 && $urandom_range(0, 3) == 0)) begin
                    s_axis_tvalid = 1'b0;
                    s_axis_tdata  = $urandom;
                    s_axis_tlast  = $urandom_range(0, 1);
                    @(negedge clk);
                end
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = d[i];
                s_axis_tlast  = (i == plen - 1);
                g = 0;
                while (!s_axis_tready && g < 200) begin
                    @(negedge clk);
                    g++;
                end
                if (g >= 200) begin
                    chk("tready_timeout", 64'(s_axis_tready), 64'd1);
                    break;
                end
                @(negedge clk);
            end
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
        end

        if (abort_at > 0) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            wq.delete();
            cq.delete();
            acc_early = 0; acc_missing = 0; acc_bad = 0;
            @(negedge clk);
            chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'd0);
            rst = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("post_rst_wr_en", 64'(wr_en), 64'd0);
                chk("post_rst_busy",  64'(busy),  64'd0);
                chk("post_rst_done",  64'(done),  64'd0);
            end
        end else begin
            g = 0;
            while (cq.size() > 0 && g < 100) begin
                @(negedge clk);
                g++;
            end
            chk("completion_pending", 64'(cq.size()), 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready),     64'd0);
        chk("rst_tready",    64'(s_axis_tready), 64'd0);
        chk("rst_wr_en",     64'(wr_en),         64'd0);
        chk("rst_wr_addr",   64'(wr_addr),       64'd0);
        chk("rst_wr_data",   64'(wr_data),       64'd0);
        chk("rst_busy",      64'(busy),          64'd0);
        chk("rst_pulses", 64'({done, err_early_last, err_missing_last, err_bad_dest}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("idle_tready",    64'(s_axis_tready), 64'd0);
        mon_en = 1'b1;

        // Parameter load: long continuous packet.
        run(0, 12672, 12672, 0, 0);
        // Image load with alternating tvalid bubbles.
        run(1, 576, 576, 1, 0);
        // Early TLAST on beat 5 of 10.
        run(2, 10, 5, 0, 0);
        // Missing TLAST: 4 expected, 7 sent.
        run(0, 4, 7, 0, 0);
        // Zero-length command.
        run(1, 0, 0, 0, 0);
        // Destination out of range.
        run(3, 5, 0, 0, 0);
        chk("bad_dest_tready", 64'(s_axis_tready), 64'd0);
        chk("bad_dest_busy",   64'(busy),          64'd0);
        // Reset after 100 of 576 beats, then a clean short command.
        run(1, 576, 576, 0, 100);
        run(2, 8, 8, 2, 0);
        // Randomized commands.
        for (int k = 0; k < 30; k++) begin
            run($urandom_range(0, 3), $urandom_range(0, 20), $urandom_range(1, 24), 2, 0);
        end

        repeat (5) @(negedge clk);
        chk("final_writes_left", 64'(wq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
